// File: rtl/rdata_packetizer_pkg.sv
`default_nettype none
// ============================================================================
// rdata_packetizer_pkg - shared types and constants for the read-data packetizer
// Rev 1.0
// ============================================================================
package rdata_packetizer_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        HOLDING = 2'd1,
        FLUSH   = 2'd2
    } state_t;

    localparam logic KEEP_ALL = 1'b1;

endpackage : rdata_packetizer_pkg
`default_nettype wire

// File: rtl/axis_out_reg.sv
`default_nettype none
// ============================================================================
// axis_out_reg - single-entry AXIS output register, reloadable while consumed
// Rev 1.0
// ============================================================================
module axis_out_reg #(
    parameter int DATA_WIDTH = 512
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_last,
    input  logic                  i_ready,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_last,
    output logic                  o_free
);

    logic                  r_valid;
    logic                  r_last;
    logic [DATA_WIDTH-1:0] r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_last  <= i_last;
            r_data  <= i_data;
        end else if (i_ready) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end
    end

    // Free when empty or being drained this cycle.
    assign o_free  = !r_valid || i_ready;
    assign o_valid = r_valid;
    assign o_last  = r_last;
    assign o_data  = r_data;

endmodule : axis_out_reg
`default_nettype wire

// File: rtl/rdata_packetizer.sv
`default_nettype none
// ============================================================================
// rdata_packetizer - re-frames single-beat read data into fixed-size packets
// Rev 1.0
// ============================================================================
module rdata_packetizer #(
    parameter int DATA_WIDTH = 512,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int CNT_WIDTH  = 16,
    parameter int TMO_WIDTH  = 16
) (
    input  logic                  axi_aclk,
    input  logic                  axi_aresetn,
    input  logic                  cfg_enable,
    input  logic [CNT_WIDTH-1:0]  cfg_pkt_beats,
    input  logic [TMO_WIDTH-1:0]  cfg_timeout,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [31:0]           stat_beats,
    output logic [31:0]           stat_pkts,
    output logic [15:0]           stat_flushes,
    output logic                  busy
);

    import rdata_packetizer_pkg::*;

    state_t                r_state;
    state_t                w_state_n;
    logic                  r_active;
    logic [CNT_WIDTH-1:0]  r_beat_idx;
    logic [CNT_WIDTH-1:0]  w_beat_idx_n;
    logic [CNT_WIDTH-1:0]  r_pkt_len;
    logic [CNT_WIDTH-1:0]  w_cfg_len;
    logic [CNT_WIDTH-1:0]  w_len;
    logic [TMO_WIDTH-1:0]  r_timer;
    logic [TMO_WIDTH-1:0]  w_timer_n;
    logic                  r_hold_valid;
    logic                  w_hold_valid_n;
    logic                  r_hold_final;
    logic                  w_hold_final_n;
    logic [DATA_WIDTH-1:0] r_hold_data;
    logic [DATA_WIDTH-1:0] w_hold_data_n;
    logic [DATA_WIDTH-1:0] w_load_data;
    logic                  w_load;
    logic                  w_load_last;
    logic                  w_out_free;
    logic                  w_accept;
    logic                  w_is_final;
    logic                  w_tmo_hit;
    logic                  w_flush_req;
    logic                  w_flush_done;
    logic                  w_hs;
    logic                  w_unused;
    logic [31:0]           r_stat_beats;
    logic [31:0]           r_stat_pkts;
    logic [15:0]           r_stat_flushes;

    assign w_unused = s_axis_tlast;

    // r_active keeps tready low while in reset and for the first cycle after.
    assign s_axis_tready = r_active && cfg_enable && (r_state != FLUSH) && w_out_free;
    assign w_accept      = s_axis_tvalid && s_axis_tready;

    assign w_cfg_len  = (cfg_pkt_beats == '0) ? CNT_WIDTH'(1) : cfg_pkt_beats;
    assign w_len      = (r_beat_idx == '0) ? w_cfg_len : r_pkt_len;
    assign w_is_final = (r_beat_idx == (w_len - CNT_WIDTH'(1)));
    assign w_tmo_hit  = (cfg_timeout != '0) && (r_timer == (cfg_timeout - TMO_WIDTH'(1)));

    // A held final beat is never flushed; it leaves as soon as the output frees.
    assign w_flush_req = (r_state == FLUSH) ||
                         ((r_state == HOLDING) && !r_hold_final && !w_accept &&
                          (!cfg_enable || w_tmo_hit));

    always_comb begin
        w_load         = 1'b0;
        w_load_data    = r_hold_data;
        w_load_last    = r_hold_final;
        w_hold_valid_n = r_hold_valid;
        w_hold_final_n = r_hold_final;
        w_hold_data_n  = r_hold_data;
        w_beat_idx_n   = r_beat_idx;
        w_flush_done   = 1'b0;

        if (w_accept) begin
            w_load = r_hold_valid;
            if (w_is_final && !r_hold_valid) begin
                w_load      = 1'b1;
                w_load_data = s_axis_tdata;
                w_load_last = 1'b1;
            end else begin
                w_hold_valid_n = 1'b1;
                w_hold_final_n = w_is_final;
                w_hold_data_n  = s_axis_tdata;
            end
            w_beat_idx_n = w_is_final ? '0 : (r_beat_idx + CNT_WIDTH'(1));
        end else if (w_flush_req) begin
            if (w_out_free) begin
                w_load         = 1'b1;
                w_load_last    = 1'b1;
                w_hold_valid_n = 1'b0;
                w_hold_final_n = 1'b0;
                w_beat_idx_n   = '0;
                w_flush_done   = 1'b1;
            end
        end else if (r_hold_valid && r_hold_final && w_out_free) begin
            w_load         = 1'b1;
            w_hold_valid_n = 1'b0;
            w_hold_final_n = 1'b0;
        end

        if (w_flush_req && !w_out_free) begin
            w_state_n = FLUSH;
        end else if (w_hold_valid_n) begin
            w_state_n = HOLDING;
        end else begin
            w_state_n = EMPTY;
        end

        if (w_accept || (w_state_n == EMPTY)) begin
            w_timer_n = '0;
        end else if ((r_state == HOLDING) && (r_timer != '1)) begin
            w_timer_n = r_timer + TMO_WIDTH'(1);
        end else begin
            w_timer_n = r_timer;
        end
    end

    assign w_hs = m_axis_tvalid && m_axis_tready;

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_state        <= EMPTY;
            r_active       <= 1'b0;
            r_beat_idx     <= '0;
            r_pkt_len      <= CNT_WIDTH'(1);
            r_timer        <= '0;
            r_hold_valid   <= 1'b0;
            r_hold_final   <= 1'b0;
            r_hold_data    <= '0;
            r_stat_beats   <= '0;
            r_stat_pkts    <= '0;
            r_stat_flushes <= '0;
        end else begin
            r_state      <= w_state_n;
            r_active     <= 1'b1;
            r_beat_idx   <= w_beat_idx_n;
            r_timer      <= w_timer_n;
            r_hold_valid <= w_hold_valid_n;
            r_hold_final <= w_hold_final_n;
            r_hold_data  <= w_hold_data_n;
            if (w_accept && (r_beat_idx == '0)) begin
                r_pkt_len <= w_cfg_len;
            end
            if (w_hs) begin
                r_stat_beats <= r_stat_beats + 32'd1;
                if (m_axis_tlast) begin
                    r_stat_pkts <= r_stat_pkts + 32'd1;
                end
            end
            if (w_flush_done) begin
                r_stat_flushes <= r_stat_flushes + 16'd1;
            end
        end
    end

    axis_out_reg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_reg (
        .clk     (axi_aclk),
        .rst_n   (axi_aresetn),
        .i_load  (w_load),
        .i_data  (w_load_data),
        .i_last  (w_load_last),
        .i_ready (m_axis_tready),
        .o_valid (m_axis_tvalid),
        .o_data  (m_axis_tdata),
        .o_last  (m_axis_tlast),
        .o_free  (w_out_free)
    );

    assign m_axis_tkeep = {KEEP_WIDTH{KEEP_ALL}};
    assign stat_beats   = r_stat_beats;
    assign stat_pkts    = r_stat_pkts;
    assign stat_flushes = r_stat_flushes;
    assign busy         = r_hold_valid || m_axis_tvalid;

endmodule : rdata_packetizer
`default_nettype wire

// File: tb/tb_rdata_packetizer.sv
`default_nettype none
// ============================================================================
// tb_rdata_packetizer - vector table, directed corner sequences, random vs model
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_rdata_packetizer;

    localparam int DW = 64;
    localparam int KW = DW / 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_en = 1'b0;
    logic [15:0]   cfg_pkt = 16'd4;
    logic [15:0]   cfg_tmo = 16'd0;
    logic [DW-1:0] s_tdata = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic          s_tlast = 1'b1;
    logic [DW-1:0] m_tdata;
    logic [KW-1:0] m_tkeep;
    logic          m_tlast;
    logic          m_tvalid;
    logic          m_tready = 1'b1;
    logic [31:0]   stat_beats;
    logic [31:0]   stat_pkts;
    logic [15:0]   stat_flushes;
    logic          busy;

    always #5 clk = ~clk;

    rdata_packetizer #(.DATA_WIDTH(DW)) dut (
        .axi_aclk      (clk),
        .axi_aresetn   (rst_n),
        .cfg_enable    (cfg_en),
        .cfg_pkt_beats (cfg_pkt),
        .cfg_timeout   (cfg_tmo),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tlast  (s_tlast),
        .m_axis_tdata  (m_tdata),
        .m_axis_tkeep  (m_tkeep),
        .m_axis_tlast  (m_tlast),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .stat_beats    (stat_beats),
        .stat_pkts     (stat_pkts),
        .stat_flushes  (stat_flushes),
        .busy          (busy)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: packet framing rules applied to the accepted-beat stream.
    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          mon_e;
    bit            mdl_pend = 1'b0;
    logic [DW-1:0] mdl_pend_data = '0;
    int            mdl_pend_cyc = 0;
    int            mdl_idx = 0;
    int            mdl_len = 1;
    int            mdl_beats = 0;
    int            mdl_pkts = 0;
    int            mdl_flushes = 0;
    int            cyc = 0;

    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL out_extra: got beat %0h, want no beat", m_tdata);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("out_data", m_tdata, mon_e.data);
                    chk("out_last", m_tlast, mon_e.last);
                    chk("out_keep", m_tkeep, {KW{1'b1}});
                    mdl_beats++;
                    if (mon_e.last) mdl_pkts++;
                end
            end
            if (s_tready && (!cfg_en || (m_tvalid && !m_tready))) begin
                n_vec++;
                n_err++;
                $display("FAIL tready_rule: got 1, want 0 (en=%0b mv=%0b mr=%0b)",
                         cfg_en, m_tvalid, m_tready);
            end
            if (s_tvalid && s_tready) begin
                if (mdl_pend) begin
                    mon_e.data = mdl_pend_data;
                    mon_e.last = 1'b0;
                    exp_q.push_back(mon_e);
                end
                if (mdl_idx == 0) mdl_len = (cfg_pkt == 16'd0) ? 1 : int'(cfg_pkt);
                if (mdl_idx == mdl_len - 1) begin
                    mon_e.data = s_tdata;
                    mon_e.last = 1'b1;
                    exp_q.push_back(mon_e);
                    mdl_pend = 1'b0;
                    mdl_idx  = 0;
                end else begin
                    mdl_pend      = 1'b1;
                    mdl_pend_data = s_tdata;
                    mdl_pend_cyc  = cyc;
                    mdl_idx++;
                end
            end else if (mdl_pend && (!cfg_en ||
                         (cfg_tmo != 16'd0 && (cyc - mdl_pend_cyc) == int'(cfg_tmo)))) begin
                mon_e.data = mdl_pend_data;
                mon_e.last = 1'b1;
                exp_q.push_back(mon_e);
                mdl_pend = 1'b0;
                mdl_idx  = 0;
                mdl_flushes++;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        s_tvalid = 1'b0;
        idle(2);
        exp_q.delete();
        mdl_pend    = 1'b0;
        mdl_idx     = 0;
        mdl_beats   = 0;
        mdl_pkts    = 0;
        mdl_flushes = 0;
        rst_n = 1'b1;
        idle(1);
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [DW-1:0] d);
        bit done;
        done     = 1'b0;
        s_tvalid = 1'b1;
        s_tdata  = d;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            done = s_tready;
            @(posedge clk);
            #1;
        end
        s_tvalid = 1'b0;
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: beat %0h not accepted, want accepted", d);
        end
    endtask

    function automatic logic [DW-1:0] dval(input int i);
        return {32'hDA7A0000 + 32'(i), 32'(i)};
    endfunction

    typedef struct {
        int pkt;
        int tmo;
        int nbeats;
        int wait_cyc;
        int exp_beats;
        int exp_pkts;
        int exp_flush;
        int exp_busy;
    } vec_t;

    vec_t vt[7];
    int   lat;
    int   bad;
    int   dctr;
    bit   acc;

    initial begin
        vt[0] = '{4, 0, 8,  5, 8, 2, 0, 0};
        vt[1] = '{0, 0, 3,  5, 3, 3, 0, 0};
        vt[2] = '{1, 0, 5,  5, 5, 5, 0, 0};
        vt[3] = '{3, 5, 7, 12, 7, 3, 1, 0};
        vt[4] = '{5, 0, 3, 10, 2, 0, 0, 1};
        vt[5] = '{2, 1, 4,  5, 4, 2, 0, 0};
        vt[6] = '{3, 2, 2,  6, 2, 1, 1, 0};

        // Reset state
        cfg_en = 1'b1;
        #2;
        chk("rst_tvalid", m_tvalid, 0);
        chk("rst_tlast", m_tlast, 0);
        chk("rst_tdata", m_tdata, 0);
        chk("rst_tready", s_tready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_stats", {stat_beats, stat_pkts}, 0);
        chk("rst_flush", stat_flushes, 0);

        for (int v = 0; v < 7; v++) begin
            do_reset();
            cfg_pkt  = 16'(vt[v].pkt);
            cfg_tmo  = 16'(vt[v].tmo);
            cfg_en   = 1'b1;
            m_tready = 1'b1;
            for (int b = 0; b < vt[v].nbeats; b++) send(dval(b + 16 * v));
            idle(vt[v].wait_cyc);
            chk($sformatf("v%0d_beats", v), stat_beats, vt[v].exp_beats);
            chk($sformatf("v%0d_pkts", v), stat_pkts, vt[v].exp_pkts);
            chk($sformatf("v%0d_flush", v), stat_flushes, vt[v].exp_flush);
            chk($sformatf("v%0d_busy", v), busy, vt[v].exp_busy);
        end

        // Timeout flush lands exactly 10 edges after the last accept
        do_reset();
        cfg_pkt = 16'd4;
        cfg_tmo = 16'd10;
        send(dval(200));
        send(dval(201));
        lat = -1;
        for (int k = 1; k <= 20 && lat < 0; k++) begin
            @(posedge clk);
            #1;
            if (m_tvalid && m_tlast && m_tdata == dval(201)) lat = k;
        end
        chk("tmo_latency", 64'(lat), 10);
        idle(2);
        chk("tmo_flushes", stat_flushes, 1);
        for (int b = 202; b < 206; b++) send(dval(b));
        idle(3);
        chk("tmo_pkts", stat_pkts, 2);
        chk("tmo_beats", stat_beats, 6);

        // Beat arriving when the timer reads timeout-1 wins over the flush
        do_reset();
        send(dval(300));
        idle(9);
        send(dval(301));
        idle(9);
        send(dval(302));
        send(dval(303));
        idle(3);
        chk("race_flushes", stat_flushes, 0);
        chk("race_pkts", stat_pkts, 1);
        chk("race_beats", stat_beats, 4);

        // pkt_beats=0 acts as 1: each beat visible right after its accept edge
        do_reset();
        cfg_pkt = 16'd0;
        cfg_tmo = 16'd0;
        for (int b = 0; b < 3; b++) begin
            send(dval(400 + b));
            chk("lat1_valid", m_tvalid, 1);
            chk("lat1_data", m_tdata, dval(400 + b));
            chk("lat1_last", m_tlast, 1);
        end
        idle(2);
        chk("lat1_pkts", stat_pkts, 3);

        // Output back-pressure for 20 cycles mid-packet
        do_reset();
        cfg_pkt  = 16'd4;
        m_tready = 1'b0;
        send(dval(500));
        send(dval(501));
        bad = 0;
        fork
            begin
                for (int b = 502; b < 508; b++) send(dval(b));
            end
            begin
                repeat (20) begin
                    @(negedge clk);
                    if (s_tready) bad++;
                end
                chk("stall_hold", m_tdata, dval(500));
                @(posedge clk);
                #1;
                m_tready = 1'b1;
            end
        join
        chk("stall_tready", 64'(bad), 0);
        idle(5);
        chk("stall_beats", stat_beats, 8);
        chk("stall_pkts", stat_pkts, 2);
        chk("stall_busy", busy, 0);

        // Disable flush, then asynchronous reset mid-packet
        do_reset();
        send(dval(600));
        idle(2);
        cfg_en = 1'b0;
        idle(3);
        chk("dis_flushes", stat_flushes, 1);
        chk("dis_pkts", stat_pkts, 1);
        cfg_en = 1'b1;
        send(dval(601));
        send(dval(602));
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_tvalid", m_tvalid, 0);
        chk("arst_tlast", m_tlast, 0);
        chk("arst_tdata", m_tdata, 0);
        chk("arst_stats", {stat_beats, stat_pkts}, 0);
        chk("arst_flush", stat_flushes, 0);
        chk("arst_busy", busy, 0);
        chk("arst_tready", s_tready, 0);
        #2;
        do_reset();

        // Randomized traffic against the model
        dctr = 1000;
        for (int seg = 0; seg < 6; seg++) begin
            int vprob;
            cfg_pkt = 16'($urandom_range(0, 5));
            cfg_tmo = ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom_range(1, 8));
            vprob   = $urandom_range(1, 9);
            acc     = 1'b1;
            for (int c = 0; c < 300; c++) begin
                if (acc || !s_tvalid) begin
                    s_tvalid = ($urandom_range(0, 9) < vprob);
                    s_tdata  = {32'($urandom), 32'(dctr)};
                end
                m_tready = ($urandom_range(0, 3) != 0);
                cfg_en   = ($urandom_range(0, 19) != 0);
                @(negedge clk);
                acc = s_tvalid && s_tready;
                @(posedge clk);
                #1;
                if (acc) dctr++;
            end
            s_tvalid = 1'b0;
            m_tready = 1'b1;
            cfg_en   = 1'b0;
            idle(4);
            cfg_en = 1'b1;
            idle(2);
            chk("rnd_beats", stat_beats, mdl_beats);
            chk("rnd_pkts", stat_pkts, mdl_pkts);
            chk("rnd_flushes", stat_flushes, mdl_flushes);
            chk("rnd_drained", 64'(exp_q.size()), 0);
            chk("rnd_busy", busy, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1);
    end

endmodule : tb_rdata_packetizer
`default_nettype wire
